// File: rtl/mem_stage_ctrl_pkg.sv
// Shared LC-3b types for the MEM-stage controller: word/opcode types,
// access-kind and state enums, and the control-word decode.
package lc3b_types;

    typedef logic [15:0] lc3b_word;

    typedef enum logic [3:0] {
        op_br   = 4'b0000,
        op_add  = 4'b0001,
        op_ldb  = 4'b0010,
        op_stb  = 4'b0011,
        op_jsr  = 4'b0100,
        op_and  = 4'b0101,
        op_ldr  = 4'b0110,
        op_str  = 4'b0111,
        op_rti  = 4'b1000,
        op_not  = 4'b1001,
        op_ldi  = 4'b1010,
        op_sti  = 4'b1011,
        op_jmp  = 4'b1100,
        op_shf  = 4'b1101,
        op_lea  = 4'b1110,
        op_trap = 4'b1111
    } lc3b_opcode;

    typedef enum logic [2:0] {
        NONE,
        WORD_RD,
        WORD_WR,
        BYTE_RD,
        BYTE_WR,
        IND_RD,
        IND_WR
    } mem_kind_t;

    typedef enum logic [1:0] {
        IDLE,
        ACC1,
        ACC2,
        DONE
    } mem_state_t;

    // Sub-word and indirect opcodes win over the generic read/write flags.
    function automatic mem_kind_t decode_kind(input logic [3:0] op, input logic rd, input logic wr);
        mem_kind_t k;
        case (lc3b_opcode'(op))
            op_ldb:  k = BYTE_RD;
            op_stb:  k = BYTE_WR;
            op_ldi:  k = IND_RD;
            op_sti:  k = IND_WR;
            default: begin
                if (rd || lc3b_opcode'(op) == op_ldr)      k = WORD_RD;
                else if (wr || lc3b_opcode'(op) == op_str) k = WORD_WR;
                else                                        k = NONE;
            end
        endcase
        return k;
    endfunction

endpackage

// File: rtl/mem_stage_ctrl_if.sv
// Data-side memory port: strobes, address, data and byte lanes out; data and resp back.
interface mem_stage_ctrl_if;
    logic        dmem_read;
    logic        dmem_write;
    logic [15:0] dmem_address;
    logic [15:0] dmem_wdata;
    logic [1:0]  dmem_byte_enable;
    logic [15:0] dmem_rdata;
    logic        dmem_resp;

    modport master (
        output dmem_read, dmem_write, dmem_address, dmem_wdata, dmem_byte_enable,
        input  dmem_rdata, dmem_resp
    );

    modport slave (
        input  dmem_read, dmem_write, dmem_address, dmem_wdata, dmem_byte_enable,
        output dmem_rdata, dmem_resp
    );
endinterface

// File: rtl/mem_stage_ctrl_byte_align.sv
// Byte-lane handling for LDB/STB: lane enables, replicated store byte and
// sign-extended load byte. Word kinds pass data through with both lanes on.
module mem_byte_align
    import lc3b_types::*;
(
    input  mem_kind_t  kind_i,
    input  logic       addr0_i,
    input  lc3b_word   wdata_i,
    input  lc3b_word   rdata_i,
    output logic [1:0] byte_en_o,
    output lc3b_word   wdata_o,
    output lc3b_word   load_o
);
    logic [7:0] lane;

    always_comb begin
        byte_en_o = 2'b11;
        wdata_o   = wdata_i;
        if (kind_i == BYTE_RD || kind_i == BYTE_WR) begin
            byte_en_o = addr0_i ? 2'b10 : 2'b01;
        end
        if (kind_i == BYTE_WR) begin
            wdata_o = {2{wdata_i[7:0]}};
        end
        lane   = addr0_i ? rdata_i[15:8] : rdata_i[7:0];
        load_o = {{8{lane[7]}}, lane};
    end
endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM-stage data-memory controller: word, byte and indirect (LDI/STI) accesses.
// Optional response timeout is enabled by defining MEM_TIMEOUT_EN.
module mem_stage_ctrl
    import lc3b_types::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid,
    input  logic [3:0]       opcode,
    input  logic             mem2_read,
    input  logic             mem2_write,
    input  logic             hold,
    input  lc3b_word         addr,
    input  lc3b_word         wdata,
    mem_stage_ctrl_if.master dmem,
    output lc3b_word         mem_rdata,
    output logic             stall,
    output logic             err
);
    mem_state_t state_q, state_d;
    mem_kind_t  kind_q, kind_d, kind_in, align_kind;
    logic       a0_q, a0_d, align_a0;
    lc3b_word   wdata_q, wdata_d, align_wdata;
    logic       rd_q, rd_d, wr_q, wr_d;
    lc3b_word   daddr_q, daddr_d, dwdata_q, dwdata_d, rdata_q, rdata_d;
    logic [1:0] be_q, be_d, al_be;
    lc3b_word   al_wdata, al_load;
    logic       resp_ok;

    assign kind_in = decode_kind(opcode, mem2_read, mem2_write);
    assign resp_ok = dmem.dmem_resp & (rd_q | wr_q);

    // Lane logic sees live inputs while launching and the latched copy afterwards.
    assign align_kind  = (state_q == IDLE) ? kind_in  : kind_q;
    assign align_a0    = (state_q == IDLE) ? addr[0]  : a0_q;
    assign align_wdata = (state_q == IDLE) ? wdata    : wdata_q;

    mem_byte_align u_align (
        .kind_i    (align_kind),
        .addr0_i   (align_a0),
        .wdata_i   (align_wdata),
        .rdata_i   (dmem.dmem_rdata),
        .byte_en_o (al_be),
        .wdata_o   (al_wdata),
        .load_o    (al_load)
    );

`ifdef MEM_TIMEOUT_EN
    logic [7:0] cnt_q, cnt_d;
    logic       err_q;
    logic       tmo;

    assign tmo = (state_q == ACC1 || state_q == ACC2) && !resp_ok
                 && (cnt_q == 8'(TIMEOUT_CYCLES - 1));
`endif

    always_comb begin
        state_d  = state_q;
        kind_d   = kind_q;
        a0_d     = a0_q;
        wdata_d  = wdata_q;
        rd_d     = rd_q;
        wr_d     = wr_q;
        daddr_d  = daddr_q;
        dwdata_d = dwdata_q;
        be_d     = be_q;
        rdata_d  = rdata_q;
        stall    = 1'b0;
        case (state_q)
            IDLE: begin
                if (valid && kind_in != NONE) begin
                    stall    = 1'b1;
                    state_d  = ACC1;
                    kind_d   = kind_in;
                    a0_d     = addr[0];
                    wdata_d  = wdata;
                    wr_d     = (kind_in == WORD_WR) || (kind_in == BYTE_WR);
                    rd_d     = !((kind_in == WORD_WR) || (kind_in == BYTE_WR));
                    daddr_d  = (kind_in == BYTE_RD || kind_in == BYTE_WR) ? addr : {addr[15:1], 1'b0};
                    be_d     = al_be;
                    dwdata_d = al_wdata;
                end
            end
            ACC1: begin
                stall = 1'b1;
                if (resp_ok) begin
                    rd_d = 1'b0;
                    wr_d = 1'b0;
                    if (kind_q == IND_RD || kind_q == IND_WR) begin
                        state_d  = ACC2;
                        daddr_d  = {dmem.dmem_rdata[15:1], 1'b0};
                        be_d     = 2'b11;
                        dwdata_d = wdata_q;
                    end else begin
                        state_d = DONE;
                        if (kind_q == WORD_RD) rdata_d = dmem.dmem_rdata;
                        if (kind_q == BYTE_RD) rdata_d = al_load;
                    end
                end
            end
            ACC2: begin
                stall = 1'b1;
                // First ACC2 cycle has no strobe: this is the mandatory one-cycle gap.
                if (!rd_q && !wr_q) begin
                    rd_d = (kind_q == IND_RD);
                    wr_d = (kind_q == IND_WR);
                end else if (resp_ok) begin
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    state_d = DONE;
                    if (kind_q == IND_RD) rdata_d = dmem.dmem_rdata;
                end
            end
            DONE: begin
                if (!hold) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
`ifdef MEM_TIMEOUT_EN
        if (tmo) begin
            rd_d    = 1'b0;
            wr_d    = 1'b0;
            state_d = DONE;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            kind_q   <= NONE;
            a0_q     <= 1'b0;
            wdata_q  <= '0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            daddr_q  <= '0;
            dwdata_q <= '0;
            be_q     <= '0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            kind_q   <= kind_d;
            a0_q     <= a0_d;
            wdata_q  <= wdata_d;
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            daddr_q  <= daddr_d;
            dwdata_q <= dwdata_d;
            be_q     <= be_d;
            rdata_q  <= rdata_d;
        end
    end

`ifdef MEM_TIMEOUT_EN
    always_comb begin
        cnt_d = '0;
        if ((state_q == ACC1 || state_q == ACC2) && state_d == state_q) cnt_d = cnt_q + 8'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= tmo;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0 & (TIMEOUT_CYCLES != 0);
`endif

    assign dmem.dmem_read        = rd_q;
    assign dmem.dmem_write       = wr_q;
    assign dmem.dmem_address     = daddr_q;
    assign dmem.dmem_wdata       = dwdata_q;
    assign dmem.dmem_byte_enable = be_q;
    assign mem_rdata             = rdata_q;
endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Randomized bench for mem_stage_ctrl against a transaction-level memory model.
// The timeout scenario runs only when MEM_TIMEOUT_EN is defined.
module tb_mem_stage_ctrl;
    import lc3b_types::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid = 1'b0;
    logic [3:0]  opcode = '0;
    logic        mem2_read = 1'b0;
    logic        mem2_write = 1'b0;
    logic        hold = 1'b0;
    logic [15:0] addr = '0;
    logic [15:0] wdata = '0;
    logic [15:0] mem_rdata;
    logic        stall;
    logic        err;

    mem_stage_ctrl_if dmem ();

    mem_stage_ctrl #(.TIMEOUT_CYCLES(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .valid      (valid),
        .opcode     (opcode),
        .mem2_read  (mem2_read),
        .mem2_write (mem2_write),
        .hold       (hold),
        .addr       (addr),
        .wdata      (wdata),
        .dmem       (dmem),
        .mem_rdata  (mem_rdata),
        .stall      (stall),
        .err        (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          wr;
        logic [15:0] a;
        logic [1:0]  be;
        logic [15:0] d;
    } acc_t;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [15:0] mem [int];
    int          fixed_lat = -1;
    logic [15:0] model_rdata = '0;
    int          n_reads = 0;
    int          n_writes = 0;
    logic [15:0] last_wr_addr = '0;
    logic [15:0] last_wr_data = '0;
    logic [1:0]  last_wr_be = '0;
    int          last_gap = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] mem_rd(input logic [15:0] a);
        int k;
        k = int'({a[15:1], 1'b0});
        if (mem.exists(k)) return mem[k];
        return {a[7:1], 1'b0, a[15:8]} ^ 16'hC35A;
    endfunction

    function automatic void mem_wr(input logic [15:0] a, input logic [15:0] d, input logic [1:0] be);
        logic [15:0] cur;
        cur = mem_rd(a);
        if (be[0]) cur[7:0]  = d[7:0];
        if (be[1]) cur[15:8] = d[15:8];
        mem[int'({a[15:1], 1'b0})] = cur;
    endfunction

    function automatic mem_kind_t ref_kind(input logic [3:0] op, input logic r, input logic w);
        if (op == 4'd2)  return BYTE_RD;
        if (op == 4'd3)  return BYTE_WR;
        if (op == 4'd10) return IND_RD;
        if (op == 4'd11) return IND_WR;
        if (r || op == 4'd6) return WORD_RD;
        if (w || op == 4'd7) return WORD_WR;
        return NONE;
    endfunction

    // Called just after a rising edge with the DUT idle; returns likewise.
    task automatic do_instr(input logic [3:0] op, input logic r, input logic w, input logic [15:0] a,
                            input logic [15:0] d, input int unsigned hold_n, output int stall_n);
        mem_kind_t   k;
        acc_t        exp_q[$];
        logic [15:0] ka, p, pa, res, wd;
        logic [7:0]  bt;
        logic [35:0] cap;
        bit          is_load, prev, strobe, done;
        int          acc_i, lat, wait_n, gap, sum_lat;

        k = ref_kind(op, r, w);
        ka = {a[15:1], 1'b0};
        is_load = 1'b0;
        res = '0;
        case (k)
            WORD_RD: begin exp_q.push_back('{0, ka, 2'b11, 16'h0}); res = mem_rd(ka); is_load = 1'b1; end
            WORD_WR: exp_q.push_back('{1, ka, 2'b11, d});
            BYTE_RD: begin
                exp_q.push_back('{0, a, a[0] ? 2'b10 : 2'b01, 16'h0});
                wd = mem_rd(ka);
                bt = a[0] ? wd[15:8] : wd[7:0];
                res = 16'(int'(bt) - (bt >= 8'd128 ? 256 : 0));
                is_load = 1'b1;
            end
            BYTE_WR: exp_q.push_back('{1, a, a[0] ? 2'b10 : 2'b01, {d[7:0], d[7:0]}});
            IND_RD, IND_WR: begin
                p = mem_rd(ka);
                pa = {p[15:1], 1'b0};
                exp_q.push_back('{0, ka, 2'b11, 16'h0});
                if (k == IND_RD) begin
                    exp_q.push_back('{0, pa, 2'b11, 16'h0});
                    res = mem_rd(pa);
                    is_load = 1'b1;
                end else begin
                    exp_q.push_back('{1, pa, 2'b11, d});
                end
            end
            default: ;
        endcase

        valid = 1'b1; opcode = op; mem2_read = r; mem2_write = w; addr = a; wdata = d;
        hold = (hold_n != 0);
        @(negedge clk);
        check_eq("launch_stall", stall, k != NONE);
        stall_n = (k != NONE) ? 1 : 0;
        dmem.dmem_resp = ($urandom_range(0, 3) == 0);
        dmem.dmem_rdata = 16'($urandom);
        if (k == NONE) begin
            check_eq("none_strobe", {dmem.dmem_read, dmem.dmem_write}, 2'b00);
            @(posedge clk); #1;
            valid = 1'b0; hold = 1'b0; dmem.dmem_resp = 1'b0;
            return;
        end

        acc_i = 0; prev = 1'b0; gap = 0; done = 1'b0; lat = 0; wait_n = 0; sum_lat = 0; cap = '0;
        for (int cyc = 0; cyc < 64 && !done; cyc++) begin
            @(posedge clk); #1;
            if (cyc == 0) begin
                valid = 1'($urandom); opcode = 4'($urandom); addr = 16'($urandom);
                wdata = 16'($urandom); mem2_read = 1'($urandom); mem2_write = 1'($urandom);
            end
            @(negedge clk);
            strobe = dmem.dmem_read | dmem.dmem_write;
            if (!stall) begin
                done = 1'b1;
            end else begin
                stall_n++;
                if (strobe && !prev) begin
                    if (acc_i < exp_q.size()) begin
                        check_eq("acc_write", dmem.dmem_write, exp_q[acc_i].wr);
                        check_eq("acc_read", dmem.dmem_read, !exp_q[acc_i].wr);
                        check_eq("acc_addr", dmem.dmem_address, exp_q[acc_i].a);
                        check_eq("acc_be", dmem.dmem_byte_enable, exp_q[acc_i].be);
                        if (exp_q[acc_i].wr) check_eq("acc_wdata", dmem.dmem_wdata, exp_q[acc_i].d);
                    end else begin
                        check_eq("extra_access", acc_i + 1, exp_q.size());
                    end
                    if (acc_i > 0) begin
                        check_eq("strobe_gap", gap, 1);
                        last_gap = gap;
                    end
                    gap = 0;
                    cap = {dmem.dmem_read, dmem.dmem_write, dmem.dmem_address,
                           dmem.dmem_byte_enable, dmem.dmem_wdata};
                    lat = (fixed_lat >= 0) ? fixed_lat : $urandom_range(0, 2);
                    sum_lat += lat;
                    wait_n = 0;
                end else if (strobe) begin
                    check_eq("acc_stable", {dmem.dmem_read, dmem.dmem_write, dmem.dmem_address,
                                            dmem.dmem_byte_enable, dmem.dmem_wdata}, cap);
                end
                if (!strobe) gap++;
                if (strobe && wait_n == lat) begin
                    dmem.dmem_resp = 1'b1;
                    if (dmem.dmem_read) begin
                        dmem.dmem_rdata = mem_rd(dmem.dmem_address);
                        n_reads++;
                    end else begin
                        dmem.dmem_rdata = 16'($urandom);
                        mem_wr(dmem.dmem_address, dmem.dmem_wdata, dmem.dmem_byte_enable);
                        n_writes++;
                        last_wr_addr = dmem.dmem_address;
                        last_wr_data = dmem.dmem_wdata;
                        last_wr_be = dmem.dmem_byte_enable;
                    end
                    acc_i++;
                end else begin
                    dmem.dmem_resp = strobe ? 1'b0 : ($urandom_range(0, 3) == 0);
                    dmem.dmem_rdata = 16'($urandom);
                    if (strobe) wait_n++;
                end
            end
            prev = strobe;
        end
        check_eq("completion_bound", done, 1'b1);
        check_eq("acc_count", acc_i, exp_q.size());
        check_eq("stall_cycles", stall_n, 1 + sum_lat + exp_q.size() + exp_q.size() - 1);
        if (is_load) model_rdata = res;
        check_eq("mem_rdata", mem_rdata, model_rdata);
        check_eq("done_strobes", {dmem.dmem_read, dmem.dmem_write}, 2'b00);
        check_eq("err_quiet", err, 1'b0);
        valid = 1'b0;
        dmem.dmem_resp = ($urandom_range(0, 3) == 0);

        for (int i = 0; i < int'(hold_n); i++) begin
            @(posedge clk); #1;
            valid = 1'b1; opcode = 4'd6; addr = 16'($urandom);
            @(negedge clk);
            check_eq("held_no_access", {stall, dmem.dmem_read, dmem.dmem_write}, 3'b000);
            dmem.dmem_resp = ($urandom_range(0, 3) == 0);
        end
        @(posedge clk); #1;
        hold = 1'b0; valid = 1'b0; dmem.dmem_resp = 1'b0;
        if (hold_n != 0) begin
            @(negedge clk);
            check_eq("held_release", {stall, dmem.dmem_read, dmem.dmem_write}, 3'b000);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no end expected end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          sn, rw0, rd0, phase, n_str;
        bit          err_seen;
        logic [3:0]  rop;
        logic [15:0] ra, rdv;
        int unsigned rh;

        dmem.dmem_resp = 1'b0;
        dmem.dmem_rdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("reset_strobes", {dmem.dmem_read, dmem.dmem_write}, 2'b00);
        check_eq("reset_bus", {dmem.dmem_address, dmem.dmem_wdata, dmem.dmem_byte_enable}, 34'h0);
        check_eq("reset_rdata", mem_rdata, 16'h0);
        check_eq("reset_stall_err", {stall, err}, 2'b00);
        @(posedge clk); #1;
        rst_n = 1'b1;

        fixed_lat = 2;
        mem[32'h1234] = 16'hBEEF;
        do_instr(4'd6, 1'b0, 1'b0, 16'h1235, 16'h0, 0, sn);
        check_eq("ldr_stall_len", sn, 4);
        check_eq("ldr_value", mem_rdata, 16'hBEEF);

        fixed_lat = -1;
        mem[32'h2000] = 16'h80AA;
        do_instr(4'd2, 1'b0, 1'b0, 16'h2001, 16'h0, 0, sn);
        check_eq("ldb_hi", mem_rdata, 16'hFF80);
        do_instr(4'd2, 1'b0, 1'b0, 16'h2000, 16'h0, 0, sn);
        check_eq("ldb_lo", mem_rdata, 16'hFFAA);

        rw0 = n_writes;
        do_instr(4'd3, 1'b0, 1'b0, 16'h3001, 16'h1234, 0, sn);
        check_eq("stb_count", n_writes - rw0, 1);
        check_eq("stb_wdata", last_wr_data, 16'h3434);
        check_eq("stb_be", last_wr_be, 2'b10);
        check_eq("stb_keeps_rdata", mem_rdata, 16'hFFAA);

        mem[32'h4000] = 16'h5003;
        mem[32'h5002] = 16'h00C0;
        rd0 = n_reads;
        last_gap = 0;
        do_instr(4'd10, 1'b0, 1'b0, 16'h4000, 16'h0, 0, sn);
        check_eq("ldi_value", mem_rdata, 16'h00C0);
        check_eq("ldi_reads", n_reads - rd0, 2);
        check_eq("ldi_gap", last_gap, 1);

        mem[32'h6000] = 16'h7001;
        rw0 = n_writes;
        do_instr(4'd11, 1'b0, 1'b0, 16'h6000, 16'hA5A5, 5, sn);
        check_eq("sti_writes", n_writes - rw0, 1);
        check_eq("sti_target", last_wr_addr, 16'h7000);
        do_instr(4'd6, 1'b0, 1'b0, 16'h7000, 16'h0, 0, sn);
        check_eq("sti_readback", mem_rdata, 16'hA5A5);

        for (int i = 0; i < 60; i++) begin
            rop = 4'($urandom);
            ra = 16'($urandom);
            rdv = 16'($urandom);
            rh = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
            do_instr(rop, $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0, ra, rdv, rh, sn);
        end

        valid = 1'b1; opcode = 4'd10; mem2_read = 1'b0; mem2_write = 1'b0; addr = 16'h4000; hold = 1'b0;
        phase = 0;
        for (int c = 0; c < 20 && phase < 2; c++) begin
            @(negedge clk);
            if (phase == 0 && dmem.dmem_read) begin
                dmem.dmem_resp = 1'b1; dmem.dmem_rdata = 16'h5003; phase = 1;
            end else if (phase == 1 && dmem.dmem_read) begin
                phase = 2;
            end else begin
                dmem.dmem_resp = 1'b0;
            end
            @(posedge clk); #1;
            valid = 1'b0;
        end
        check_eq("rst_reached_acc2", phase, 2);
        #2 rst_n = 1'b0;
        #1;
        check_eq("rst_drops_strobe", {dmem.dmem_read, dmem.dmem_write}, 2'b00);
        check_eq("rst_stall", stall, 1'b0);
        check_eq("rst_rdata", mem_rdata, 16'h0);
        model_rdata = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        do_instr(4'd10, 1'b0, 1'b0, 16'h4000, 16'h0, 0, sn);
        check_eq("post_rst_ldi", mem_rdata, 16'h00C0);

`ifdef MEM_TIMEOUT_EN
        valid = 1'b1; opcode = 4'd6; addr = 16'h0100; dmem.dmem_resp = 1'b0;
        n_str = 0; err_seen = 1'b0;
        for (int c = 0; c < 20 && !err_seen; c++) begin
            @(negedge clk);
            if (dmem.dmem_read) n_str++;
            if (err) begin
                err_seen = 1'b1;
                check_eq("tmo_done_quiet", {stall, dmem.dmem_read}, 2'b00);
            end
            @(posedge clk); #1;
            valid = 1'b0;
        end
        check_eq("tmo_err_seen", err_seen, 1'b1);
        check_eq("tmo_strobe_cycles", n_str, 4);
        check_eq("tmo_rdata_kept", mem_rdata, model_rdata);
        @(negedge clk);
        check_eq("tmo_err_pulse", err, 1'b0);
        @(posedge clk); #1;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
